// File: rtl/somador_serial.sv
// Bit-serial N-bit adder around the 1-bit full adder somador; optional ovf port via SOMADOR_SERIAL_OVF_EN.
// Latency: start accepted at edge k gives a done pulse after edge k+N. start is only honoured while pronto, with no queuing.

module somador (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic saida1,
  output logic saida2
);
  assign saida1 = a ^ b ^ c;
  assign saida2 = (a & b) | (c & (a ^ b));
endmodule

module somador_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin,
  output logic         pronto,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] soma,
  output logic         cout
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOMA = 2'd1,
    FIM  = 2'd2
  } estado_t;

  estado_t       estado;
  estado_t       prox;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  acum;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          s_bit;
  logic          c_bit;
  logic          ultimo_bit;

  somador u_somador (
    .a      (op_a[0]),
    .b      (op_b[0]),
    .c      (carry),
    .saida1 (s_bit),
    .saida2 (c_bit)
  );

  assign ultimo_bit = (estado == SOMA) && (cnt == ULTIMO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado <= IDLE;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox   = estado;
    pronto = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (estado)
      IDLE: begin
        pronto = 1'b1;
        if (start) prox = SOMA;
      end
      SOMA: begin
        busy = 1'b1;
        if (cnt == ULTIMO) prox = FIM;
      end
      FIM: begin
        done = 1'b1;
        prox = IDLE;
      end
      default: prox = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so bit 0 lands at the LSB after N shifts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_a  <= '0;
      op_b  <= '0;
      acum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      soma  <= '0;
      cout  <= 1'b0;
    end else if (estado == IDLE) begin
      if (start) begin
        op_a  <= a_in;
        op_b  <= b_in;
        carry <= cin;
        cnt   <= '0;
      end
    end else if (estado == SOMA) begin
      op_a  <= {1'b0, op_a[N-1:1]};
      op_b  <= {1'b0, op_b[N-1:1]};
      acum  <= {s_bit, acum[N-1:1]};
      carry <= c_bit;
      cnt   <= cnt + 1'b1;
      if (ultimo_bit) begin
        soma <= {s_bit, acum[N-1:1]};
        cout <= c_bit;
      end
    end
  end

`ifdef SOMADOR_SERIAL_OVF_EN
  // carry holds the carry into the MSB during the final SOMA cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (ultimo_bit) begin
      ovf <= carry ^ c_bit;
    end
  end
`endif

endmodule
